// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: owns the fetch PC, issues single-outstanding
// word requests to instruction memory and buffers returned words in a FIFO
// whose head is presented to decode through a valid/ready handshake.
module ifu_prefetch #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            redirect_en_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_data_o,
  output logic [XLEN-1:0] inst_pc_o,
  input  logic            inst_ready_i
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   pending_pc_q, pending_pc_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [XLEN-1:0]   data_mem_q [DEPTH];
  logic [XLEN-1:0]   data_mem_d [DEPTH];
  logic [XLEN-1:0]   pc_mem_q   [DEPTH];
  logic [XLEN-1:0]   pc_mem_d   [DEPTH];
  logic              req_q, req_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   head_data_q, head_data_d;
  logic [XLEN-1:0]   head_pc_q, head_pc_d;
  logic              push_c;
  logic              pop_c;

  // Next-state: FIFO bookkeeping, fetch FSM, registered bus and head outputs
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    data_mem_d   = data_mem_q;
    pc_mem_d     = pc_mem_q;
    req_d        = 1'b0;
    addr_d       = '0;
    valid_d      = 1'b0;
    head_data_d  = '0;
    head_pc_d    = '0;

    // Redirect overrides both FIFO ports in the same cycle
    push_c = (state_q == S_WAIT) && imem_rvalid_i && !redirect_en_i;
    pop_c  = valid_q && inst_ready_i && !redirect_en_i;

    if (push_c) begin
      data_mem_d[wr_ptr_q] = imem_rdata_i;
      pc_mem_d[wr_ptr_q]   = pending_pc_q;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

    if (redirect_en_i) begin
      fetch_pc_d = redirect_pc_i & ~XLEN'(3);
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (!redirect_en_i && (count_q < CNT_W'(DEPTH))) state_d = S_REQ;
      end
      S_REQ: begin
        if (imem_gnt_i) begin
          // A granted request is outstanding even if we redirect now
          state_d      = redirect_en_i ? S_DRAIN : S_WAIT;
          pending_pc_d = fetch_pc_q;
          if (!redirect_en_i) fetch_pc_d = fetch_pc_q + XLEN'(4);
        end else if (redirect_en_i) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          if (redirect_en_i)                      state_d = S_IDLE;
          else if (count_d < CNT_W'(DEPTH))       state_d = S_REQ;
          else                                    state_d = S_IDLE;
        end else if (redirect_en_i) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_REQ) begin
      req_d  = 1'b1;
      addr_d = fetch_pc_d;
    end

    // Head reads the post-write image so a push into an empty FIFO shows next cycle
    if (count_d != '0) begin
      valid_d     = 1'b1;
      head_data_d = data_mem_d[rd_ptr_d];
      head_pc_d   = pc_mem_d[rd_ptr_d];
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
      req_q        <= 1'b0;
      addr_q       <= '0;
      valid_q      <= 1'b0;
      head_data_q  <= '0;
      head_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_mem_q   <= data_mem_d;
      pc_mem_q     <= pc_mem_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      head_data_q  <= head_data_d;
      head_pc_q    <= head_pc_d;
    end
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = addr_q;
  assign inst_valid_o = valid_q;
  assign inst_data_o  = head_data_q;
  assign inst_pc_o    = head_pc_q;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: streaming, backpressure, redirects,
// PC wraparound and reset during an outstanding fetch.
module tb_ifu_prefetch;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        redirect_en_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_data_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int waited;

  localparam logic [31:0] STALE = 32'hDEAD_BEEF;

  ifu_prefetch #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .redirect_en_i (redirect_en_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_data_o   (inst_data_o),
    .inst_pc_o     (inst_pc_o),
    .inst_ready_i  (inst_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req"},   64'(imem_req_o),   64'(0));
    check({tag, "_addr"},  64'(imem_addr_o),  64'(0));
    check({tag, "_valid"}, 64'(inst_valid_o), 64'(0));
    check({tag, "_data"},  64'(inst_data_o),  64'(0));
    check({tag, "_pc"},    64'(inst_pc_o),    64'(0));
  endtask

  task automatic do_reset(input string tag);
    rst_i = 1'b1;
    redirect_en_i = 1'b0;
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    inst_ready_i = 1'b0;
    step();
    step();
    check_idle_outputs(tag);
    rst_i = 1'b0;
  endtask

  // Bounded wait for a request; reports the number of idle cycles seen
  task automatic wait_req(input string tag, output int n);
    n = 0;
    while (!imem_req_o && n < 20) begin
      step();
      n++;
    end
    check({tag, "_req_seen"}, 64'(imem_req_o), 64'(1));
  endtask

  // One complete fetch: 1-cycle grant, response in the following cycle
  task automatic fetch_one(input string tag, input logic [31:0] exp_addr, output int n);
    wait_req(tag, n);
    check({tag, "_addr"}, 64'(imem_addr_o), 64'(exp_addr));
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = data_of(exp_addr);
    step();
    imem_rvalid_i = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, 64'(inst_valid_o), 64'(1));
    check({tag, "_pc"},    64'(inst_pc_o),    64'(pc));
    check({tag, "_data"},  64'(inst_data_o),  64'(data_of(pc)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: streaming with decode always ready
    do_reset("t1_rst");
    inst_ready_i = 1'b1;
    fetch_one("t1_w0", 32'h0, waited);
    check_head("t1_h0", 32'h0);
    fetch_one("t1_w1", 32'h4, waited);
    check("t1_gap1", 64'(waited), 64'(0));
    check_head("t1_h1", 32'h4);
    fetch_one("t1_w2", 32'h8, waited);
    check("t1_gap2", 64'(waited), 64'(0));
    check_head("t1_h2", 32'h8);

    // 2: backpressure fills the FIFO, then drains in order
    do_reset("t2_rst");
    for (int k = 0; k < 4; k++) fetch_one("t2_fill", 32'(4 * k), waited);
    for (int k = 0; k < 3; k++) begin
      check("t2_full_req", 64'(imem_req_o), 64'(0));
      check_head("t2_hold", 32'h0);
      step();
    end
    inst_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_head("t2_pop", 32'(4 * k));
      step();
    end
    inst_ready_i = 1'b0;
    check("t2_empty", 64'(inst_valid_o), 64'(0));
    check("t2_resume_req", 64'(imem_req_o), 64'(1));
    check("t2_resume_addr", 64'(imem_addr_o), 64'(32'h10));
    fetch_one("t2_w4", 32'h10, waited);
    check_head("t2_h4", 32'h10);

    // 3: redirect while waiting for a response
    do_reset("t3_rst");
    fetch_one("t3_w0", 32'h0, waited);
    check_head("t3_h0", 32'h0);
    wait_req("t3_w1", waited);
    check("t3_w1_addr", 64'(imem_addr_o), 64'(32'h4));
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    redirect_en_i = 1'b1;
    redirect_pc_i = 32'h103;
    step();
    redirect_en_i = 1'b0;
    check("t3_flush_valid", 64'(inst_valid_o), 64'(0));
    check("t3_flush_pc", 64'(inst_pc_o), 64'(0));
    imem_rvalid_i = 1'b1;
    imem_rdata_i = STALE;
    step();
    imem_rvalid_i = 1'b0;
    check("t3_stale_valid", 64'(inst_valid_o), 64'(0));
    check("t3_drain_req", 64'(imem_req_o), 64'(0));
    fetch_one("t3_w2", 32'h100, waited);
    check_head("t3_h2", 32'h100);

    // 4a: redirect in the same cycle as grant
    do_reset("t4a_rst");
    inst_ready_i = 1'b1;
    wait_req("t4a_w0", waited);
    imem_gnt_i = 1'b1;
    redirect_en_i = 1'b1;
    redirect_pc_i = 32'h200;
    step();
    imem_gnt_i = 1'b0;
    redirect_en_i = 1'b0;
    check("t4a_req", 64'(imem_req_o), 64'(0));
    check("t4a_valid0", 64'(inst_valid_o), 64'(0));
    imem_rvalid_i = 1'b1;
    imem_rdata_i = STALE;
    step();
    imem_rvalid_i = 1'b0;
    check("t4a_valid1", 64'(inst_valid_o), 64'(0));
    fetch_one("t4a_w1", 32'h200, waited);
    check_head("t4a_h1", 32'h200);

    // 4b: redirect in the same cycle as the response
    do_reset("t4b_rst");
    fetch_one("t4b_w0", 32'h0, waited);
    wait_req("t4b_w1", waited);
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = STALE;
    redirect_en_i = 1'b1;
    redirect_pc_i = 32'h300;
    step();
    imem_rvalid_i = 1'b0;
    redirect_en_i = 1'b0;
    check("t4b_valid", 64'(inst_valid_o), 64'(0));
    check("t4b_req", 64'(imem_req_o), 64'(0));
    fetch_one("t4b_w2", 32'h300, waited);
    check_head("t4b_h2", 32'h300);

    // 5: fetch PC wraps past the top of the address space
    do_reset("t5_rst");
    redirect_en_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFE;
    step();
    redirect_en_i = 1'b0;
    fetch_one("t5_w0", 32'hFFFF_FFFC, waited);
    fetch_one("t5_w1", 32'h0, waited);
    check_head("t5_h0", 32'hFFFF_FFFC);

    // 6: reset while a response is outstanding
    do_reset("t6_rst");
    wait_req("t6_w0", waited);
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    rst_i = 1'b1;
    step();
    check_idle_outputs("t6_inrst");
    rst_i = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = STALE;
    step();
    imem_rvalid_i = 1'b0;
    check("t6_valid", 64'(inst_valid_o), 64'(0));
    check("t6_req", 64'(imem_req_o), 64'(1));
    fetch_one("t6_w1", 32'h0, waited);
    check_head("t6_h1", 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
